pipe_adder: RTL and testbench

Pipelined, parametrised add/subtract unit with valid/ready flow control. It is the registered successor to the lab's 9-bit combinational adder. The carry chain is split into SEG-bit slices, one slice per pipeline stage, so WIDTH can grow without lengthening the critical path. It sits between operand producers (switch/datapath logic) and any consumer that can apply backpressure, such as display drivers or a downstream accumulator.

---
 rtl/pipe_adder_pkg.sv | 24 ++
 rtl/adder_slice.sv | 39 +++
 rtl/pipe_adder.sv | 120 ++++++++++++
 tb/tb_pipe_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int nstage(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // The top slice takes whatever bits remain after the full-width slices.
    function automatic int slice_width(input int width, input int seg, input int k);
        int last;
        last = nstage(width, seg) - 1;
        if (k == last) begin
            return width - (last * seg);
        end else begin
            return seg;
        end
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered SEG-bit ripple slice of the pipelined adder; the register
// only loads when the pipeline advances with a valid beat at its input.
module adder_slice #(
    parameter int SEG = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG:0]   total_d;
    logic [SEG-1:0] sum_q;
    logic           cout_q;

    // Slice sum including the incoming carry
    always_comb begin
        total_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
    end

    // Slice result register with hold enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= total_d[SEG-1:0];
            cout_q <= total_d[SEG];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready flow control: one carry
// slice per stage, with a single global stall driven by the output side.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int SEG   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             borrow
);

    localparam int NSTAGE = nstage(WIDTH, SEG);
    localparam int LAST   = NSTAGE - 1;

    logic adv_s;

    // Per-stage pipeline registers; operands are kept pre-shifted so each
    // stage always consumes the low bits of what it receives.
    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] sub_q;
    logic [WIDTH-1:0]  a_q   [NSTAGE];
    logic [WIDTH-1:0]  b_q   [NSTAGE];
    logic [WIDTH-1:0]  res_q [NSTAGE];

    // Stage inputs as seen before the register of that stage
    logic [NSTAGE-1:0]             vin_s;
    logic [NSTAGE-1:0]             sub_in_s;
    logic [NSTAGE-1:0]             cin_s;
    logic [NSTAGE-1:0]             cout_s;
    logic [NSTAGE-1:0][WIDTH-1:0]  a_in_s;
    logic [NSTAGE-1:0][WIDTH-1:0]  b_in_s;
    logic [NSTAGE-1:0][WIDTH-1:0]  lo_in_s;
    logic [NSTAGE-1:0][WIDTH-1:0]  sum_full_s;

    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int SW = slice_width(WIDTH, SEG, k);

        logic [SW-1:0] sa_s;
        logic [SW-1:0] sb_s;
        logic [SW-1:0] sum_s;

        if (k == 0) begin : g_first
            // Carry-in of 1 on the first slice completes the two's complement of b.
            assign vin_s[k]    = in_valid;
            assign sub_in_s[k] = (op_t'(op) == OP_SUB);
            assign cin_s[k]    = (op_t'(op) == OP_SUB);
            assign a_in_s[k]   = a;
            assign b_in_s[k]   = b;
            assign lo_in_s[k]  = '0;
        end else begin : g_rest
            assign vin_s[k]    = valid_q[k-1];
            assign sub_in_s[k] = sub_q[k-1];
            assign cin_s[k]    = cout_s[k-1];
            assign a_in_s[k]   = a_q[k-1];
            assign b_in_s[k]   = b_q[k-1];
            assign lo_in_s[k]  = res_q[k-1] | sum_full_s[k-1];
        end

        assign sa_s = a_in_s[k][SW-1:0];
        assign sb_s = b_in_s[k][SW-1:0] ^ {SW{sub_in_s[k]}};

        adder_slice #(
            .SEG (SW)
        ) u_slice (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (adv_s & vin_s[k]),
            .a_i     (sa_s),
            .b_i     (sb_s),
            .cin_i   (cin_s[k]),
            .sum_o   (sum_s),
            .cout_o  (cout_s[k])
        );

        assign sum_full_s[k] = WIDTH'(sum_s) << (k * SEG);
    end

    // Valid bits shift on every advance; data only loads behind a valid beat,
    // so the last stage keeps the most recent result across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            sub_q   <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else if (adv_s) begin
            valid_q <= vin_s;
            for (int k = 0; k < NSTAGE; k++) begin
                if (vin_s[k]) begin
                    sub_q[k] <= sub_in_s[k];
                    a_q[k]   <= a_in_s[k] >> SEG;
                    b_q[k]   <= b_in_s[k] >> SEG;
                    res_q[k] <= lo_in_s[k];
                end
            end
        end
    end

    // For SUB the final carry is "no borrow", so the result MSB is its inverse.
    assign out_valid = valid_q[LAST];
    assign out       = {sub_q[LAST] ^ cout_s[LAST], res_q[LAST] | sum_full_s[LAST]};
    assign borrow    = sub_q[LAST] & ~cout_s[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors on a WIDTH=9/SEG=3
// instance plus randomized streams on three parameter sets.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    logic start_rand = 1'b0;

    logic       reset_n, in_valid, in_ready, op, out_valid, out_ready, borrow;
    logic [8:0] a, b;
    logic [9:0] out;

    pipe_adder #(.WIDTH(9), .SEG(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .borrow(borrow)
    );

    typedef struct packed {
        logic       op;
        logic [8:0] a;
        logic [8:0] b;
        logic [9:0] res;
        logic       brw;
    } vec_t;

    localparam int NT = 10;
    vec_t tab [NT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        op       = v.op;
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
    endtask

    int   r, s, ghost;
    logic stall_seen;
    logic [9:0] held;

    initial begin
        tab[0] = '{1'b0, 9'h000, 9'h001, 10'h001, 1'b0};
        tab[1] = '{1'b0, 9'h1FE, 9'h001, 10'h1FF, 1'b0};
        tab[2] = '{1'b0, 9'h1FF, 9'h001, 10'h200, 1'b0};
        tab[3] = '{1'b0, 9'h1FF, 9'h1FF, 10'h3FE, 1'b0};
        tab[4] = '{1'b1, 9'h005, 9'h003, 10'h002, 1'b0};
        tab[5] = '{1'b1, 9'h000, 9'h001, 10'h3FF, 1'b1};
        tab[6] = '{1'b1, 9'h1AA, 9'h1AA, 10'h000, 1'b0};
        tab[7] = '{1'b1, 9'h000, 9'h1FF, 10'h201, 1'b1};
        tab[8] = '{1'b1, 9'h1FF, 9'h000, 10'h1FF, 1'b0};
        tab[9] = '{1'b0, 9'h155, 9'h0AA, 10'h1FF, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = 9'h000; b = 9'h000; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 10'h000);
        check("rst_borrow", borrow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single beat: latency and hold-after-consume
        drive(tab[0]);
        @(posedge clk); #1; in_valid = 1'b0;
        check("lat_e0_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_e1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_e2_valid", out_valid, 1'b1);
        check("lat_out", out, 10'h001);
        check("lat_borrow", borrow, 1'b0);
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1'b0);
        check("hold_out", out, 10'h001);

        // Back-to-back table stream, order preserved
        r = 0;
        for (int i = 0; i < NT + 8; i++) begin
            if (i < NT) drive(tab[i]); else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                if (r < NT) begin
                    check($sformatf("tab%0d_out", r), out, tab[r].res);
                    check($sformatf("tab%0d_borrow", r), borrow, tab[r].brw);
                end else begin
                    check("tab_extra_beat", 1'b1, 1'b0);
                end
                r++;
            end
            @(posedge clk); #1;
        end
        check("tab_count", r, NT);

        // Backpressure: out_ready low for 4 cycles mid-stream
        s = 0; r = 0; stall_seen = 1'b0; held = '0;
        for (int c = 0; c < 40 && r < 6; c++) begin
            out_ready = !(c >= 4 && c < 8);
            if (s < 6) drive(tab[s]); else in_valid = 1'b0;
            @(negedge clk);
            if (!out_ready && out_valid) begin
                check("bp_in_ready", in_ready, 1'b0);
                if (stall_seen) check("bp_hold_out", out, held);
                held = out;
                stall_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp%0d_out", r), out, tab[r].res);
                r++;
            end
            if (in_valid && in_ready) s++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_stall_seen", stall_seen, 1'b1);
        check("bp_count", r, 6);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_extra", out_valid, 1'b0);

        // Reset with three beats in flight
        for (int i = 4; i < 7; i++) begin
            drive(tab[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_pre_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_out", out, 10'h000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ghost = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("mid_ghost_beats", ghost, 0);
        @(posedge clk); #1;
        drive(tab[5]);
        @(posedge clk); #1; in_valid = 1'b0;
        check("mid_e0_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("mid_e1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("mid_e2_valid", out_valid, 1'b1);
        check("mid_out", out, 10'h3FF);
        check("mid_borrow", borrow, 1'b1);

        start_rand = 1'b1;
        wait (done_cnt == 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

    // Random streams with random backpressure against an arithmetic model
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int RW = (g == 0) ? 9 : (g == 1) ? 8 : 10;
        localparam int RS = (g == 0) ? 3 : (g == 1) ? 8 : 4;
        localparam int NBEAT  = 1000;
        localparam int BUDGET = 10000;

        logic          r_rst_n, r_iv, r_ir, r_op, r_ov, r_or, r_br;
        logic [RW-1:0] r_a, r_b;
        logic [RW:0]   r_out;

        pipe_adder #(.WIDTH(RW), .SEG(RS)) u_rdut (
            .clk(clk), .reset_n(r_rst_n), .in_valid(r_iv), .in_ready(r_ir),
            .op(r_op), .a(r_a), .b(r_b), .out_valid(r_ov), .out_ready(r_or),
            .out(r_out), .borrow(r_br)
        );

        initial begin
            logic [RW+1:0] sb [16];
            logic [RW:0]   ea, eb, er;
            int            head, tail, sent, got, cyc;
            logic          pending;

            head = 0; tail = 0; sent = 0; got = 0; cyc = 0; pending = 1'b0;
            r_rst_n = 1'b0; r_iv = 1'b0; r_op = 1'b0; r_a = '0; r_b = '0; r_or = 1'b0;
            wait (start_rand);
            repeat (2) @(posedge clk);
            #1;
            r_rst_n = 1'b1;
            @(posedge clk); #1;
            while (got < NBEAT && cyc < BUDGET) begin
                if (!pending) begin
                    if (sent < NBEAT && $urandom_range(3, 0) != 0) begin
                        r_iv = 1'b1;
                        r_a  = RW'($urandom);
                        r_b  = RW'($urandom);
                        r_op = 1'($urandom);
                    end else begin
                        r_iv = 1'b0;
                    end
                end
                r_or = ($urandom_range(2, 0) != 0);
                @(negedge clk);
                if (r_ov && r_or) begin
                    if (head == tail) begin
                        check($sformatf("rand%0d_spurious", g), 1'b1, 1'b0);
                    end else begin
                        check($sformatf("rand%0d_out", g), r_out, sb[head][RW:0]);
                        check($sformatf("rand%0d_borrow", g), r_br, sb[head][RW+1]);
                        head = (head + 1) % 16;
                        got++;
                    end
                end
                if (r_iv && r_ir) begin
                    ea = {1'b0, r_a};
                    eb = {1'b0, r_b};
                    er = r_op ? (ea - eb) : (ea + eb);
                    sb[tail] = {(r_op && (r_a < r_b)), er};
                    tail = (tail + 1) % 16;
                    sent++;
                    pending = 1'b0;
                end else begin
                    pending = r_iv;
                end
                @(posedge clk); #1;
                cyc++;
            end
            r_iv = 1'b0;
            check($sformatf("rand%0d_beats", g), got, NBEAT);
            done_cnt++;
        end
    end

endmodule
